// File: rtl/span_pkg.sv
// Shared span record layout and rasterizer state encoding.
// Also imported by the triangle scan stage so both ends agree on field positions.
package span_pkg;

  localparam int X_W    = 11;
  localparam int Y_W    = 9;
  localparam int REC_W  = 31;
  localparam int XL_LSB = 0;
  localparam int XR_LSB = 11;
  localparam int Y_LSB  = 22;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/span_unpack.sv
// Combinational decode of one span record: field split, drop test and right-edge clamp.
module span_unpack
  import span_pkg::*;
(
  input  logic [REC_W-1:0] span_data,
  input  logic [X_W-1:0]   x_max,
  input  logic [Y_W-1:0]   y_max,
  output logic [X_W-1:0]   xl,
  output logic [X_W-1:0]   xe,
  output logic [Y_W-1:0]   y,
  output logic             drop
);

  logic [X_W-1:0] xr;

  assign xl = span_data[XL_LSB +: X_W];
  assign xr = span_data[XR_LSB +: X_W];
  assign y  = span_data[Y_LSB +: Y_W];

  assign drop = (xl > xr) || (xl > x_max) || (y > y_max);
  assign xe   = (xr > x_max) ? x_max : xr;

endmodule

// File: rtl/span_rasterizer.sv
// Expands accepted span records into a backpressured stream of pixel coordinates,
// chaining the next record on the final-pixel handshake so consecutive spans have no bubble.
module span_rasterizer
  import span_pkg::*;
#(
  parameter int X_MAX = 1505,
  parameter int Y_MAX = 480
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             span_valid,
  output logic             span_ready,
  input  logic [REC_W-1:0] span_data,
  input  logic             span_last,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic             pix_eos,
  output logic             frame_done,
  output logic             busy,
  output logic [15:0]      span_count,
  output logic [7:0]       drop_count
);

  localparam logic [X_W-1:0] X_MAX_L = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_MAX_L = Y_W'(Y_MAX);

  state_t         state, state_n;
  logic [X_W-1:0] x_q, xe_q;
  logic [Y_W-1:0] y_q;
  logic           last_q;

  logic [X_W-1:0] u_xl, u_xe;
  logic [Y_W-1:0] u_y;
  logic           u_drop;

  logic at_end, final_hs, accept, load, advance, drop_inc, done_n;

  span_unpack u_unpack (
    .span_data (span_data),
    .x_max     (X_MAX_L),
    .y_max     (Y_MAX_L),
    .xl        (u_xl),
    .xe        (u_xe),
    .y         (u_y),
    .drop      (u_drop)
  );

  assign at_end     = (x_q == xe_q);
  assign final_hs   = (state == EMIT) && pix_ready && at_end;
  assign span_ready = (state == IDLE) || final_hs;
  assign accept     = span_valid && span_ready;
  assign drop_inc   = accept && u_drop;
  // Held-span and chained-drop completions in one cycle merge into a single pulse.
  assign done_n     = (drop_inc && span_last) || (final_hs && last_q);

  assign pix_valid = (state == EMIT);
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_eos   = (state == EMIT) && at_end;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    load    = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !u_drop) begin
          load    = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (pix_ready) begin
          if (at_end) begin
            if (accept && !u_drop) load = 1'b1;
            else                   state_n = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state      <= IDLE;
      x_q        <= '0;
      xe_q       <= '0;
      y_q        <= '0;
      last_q     <= 1'b0;
      frame_done <= 1'b0;
      span_count <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_n;
      frame_done <= done_n;
      if (load) begin
        x_q    <= u_xl;
        xe_q   <= u_xe;
        y_q    <= u_y;
        last_q <= span_last;
      end else if (advance) begin
        x_q <= x_q + 1'b1;
      end
      if (final_hs) span_count <= span_count + 16'd1;
      if (drop_inc && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

endmodule
